// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and trap cause codes for the multi-cycle sequencer
package seq_pkg;
  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd7
  } state_t;
  typedef enum logic [1:0] {
    C_NONE    = 2'd0,
    C_ILLEGAL = 2'd1,
    C_IMEM    = 2'd2,
    C_DMEM    = 2'd3
  } cause_t;
endpackage

// File: rtl/seq_timeout_cnt.sv
// seq_timeout_cnt: clear/enable counter flagging the LIMIT-th enabled cycle
module seq_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign expire = en && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: RV32I multi-cycle control FSM; perf counters under SEQ_PERF_CNT_EN
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef SEQ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_write,
  input  logic       dec_branch,
  input  logic       dec_mem_write,
  input  logic       dec_reg_write,
  input  logic       dec_mem_to_reg,
  input  logic       dec_ill_instr,
  input  logic       alu_zero,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       pc_write,
  output logic       pc_branch,
  output logic       rf_write,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
`ifdef SEQ_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`endif
);
  state_t state_q, state_d;
  cause_t cause_q, cause_d;
  logic expire;
  seq_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .clk(clk),
    .clr(!rst_n || state_d != state_q),
    .en(state_q == S_FETCH || state_q == S_MEM),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cause_q <= C_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    imem_req = 1'b0;
    ir_write = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    pc_write = 1'b0;
    pc_branch = 1'b0;
    rf_write = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          state_d = S_DECODE;
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = C_IMEM;
        end
      end
      S_DECODE: begin
        state_d = dec_ill_instr ? S_TRAP : S_EXECUTE;
        cause_d = dec_ill_instr ? C_ILLEGAL : cause_q;
      end
      S_EXECUTE: begin
        if (dec_mem_write || dec_mem_to_reg) state_d = S_MEM;
        else if (dec_reg_write) state_d = S_WB;
        else begin
          pc_write = 1'b1;
          pc_branch = dec_branch & alu_zero;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we = dec_mem_write;
        if (dmem_ack) begin
          pc_write = dec_mem_write;
          state_d = dec_mem_write ? S_FETCH : S_WB;
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = C_DMEM;
        end
      end
      S_WB: begin
        rf_write = 1'b1;
        pc_write = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RESET;
    endcase
  end
  assign trap = state_q == S_TRAP;
  assign trap_cause = cause_q;
  assign state = state_q;
`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instret_count <= '0;
    end else begin
      if (state_q != S_RESET) cycle_count <= cycle_count + 1'b1;
      if (pc_write) instret_count <= instret_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: replays a rule-built per-cycle trace of random instructions against the sequencer
module tb_multicycle_sequencer;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
  logic dec_branch = 1'b0, dec_mem_write = 1'b0, dec_reg_write = 1'b0, dec_mem_to_reg = 1'b0, dec_ill_instr = 1'b0;
  logic imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_branch, rf_write, trap;
  logic [1:0] trap_cause;
  logic [2:0] state;
  typedef struct packed {
    logic rst_n, ia, da;
    logic [4:0] dec;
    logic az;
    logic [12:0] exp;
  } step_t;
  step_t q[$];
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  multicycle_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_write(ir_write),
    .dec_branch(dec_branch), .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
    .dec_mem_to_reg(dec_mem_to_reg), .dec_ill_instr(dec_ill_instr), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .pc_branch(pc_branch), .rf_write(rf_write),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );
  function automatic logic r1();
    return 1'($urandom);
  endfunction
  function automatic logic [4:0] rnd();
    return 5'($urandom);
  endfunction
  function automatic logic [12:0] e(input int st, c, ireq, irw, dreq, dwe, pcw, pcb, rfw);
    return {3'(st), 1'(st == 7), 2'(c), 1'(ireq), 1'(irw), 1'(dreq), 1'(dwe), 1'(pcw), 1'(pcb), 1'(rfw)};
  endfunction
  function automatic void push(input int r, ia, da, input logic [4:0] dec, input logic az, input logic [12:0] x);
    q.push_back({1'(r), 1'(ia), 1'(da), dec, az, x});
  endfunction
  function automatic void reset_rec();
    push(1, r1(), r1(), rnd(), r1(), e(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endfunction
  function automatic void trap_seq(input int c);
    int n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) push(1, r1(), r1(), rnd(), r1(), e(7, c, 0, 0, 0, 0, 0, 0, 0));
    push(0, r1(), r1(), rnd(), r1(), e(7, c, 0, 0, 0, 0, 0, 0, 0));
    reset_rec();
  endfunction
  function automatic void instr(input int kind, fd, md, input logic az, input bit abort);
    logic [4:0] d;
    int st = (kind == 2) ? 1 : 0;
    d = kind == 0 ? 5'b01000 : kind == 1 ? 5'b01100 : kind == 2 ? 5'b10000 :
        kind == 3 ? 5'b00010 : {4'($urandom), 1'b1};
    for (int i = 0; i < fd && i < T; i++) push(1, 0, r1(), rnd(), r1(), e(1, 0, 1, 0, 0, 0, 0, 0, 0));
    if (fd >= T) begin
      trap_seq(2);
      return;
    end
    push(1, 1, r1(), rnd(), r1(), e(1, 0, 1, 1, 0, 0, 0, 0, 0));
    push(1, r1(), r1(), d, az, e(2, 0, 0, 0, 0, 0, 0, 0, 0));
    if (kind == 4) begin
      trap_seq(1);
      return;
    end
    push(1, r1(), r1(), d, az, e(3, 0, 0, 0, 0, 0, kind == 3, kind == 3 && az, 0));
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i < md && i < T; i++) begin
        if (abort && i == 1) begin
          push(0, r1(), 0, d, az, e(4, 0, 0, 0, 1, st, 0, 0, 0));
          reset_rec();
          return;
        end
        push(1, r1(), 0, d, az, e(4, 0, 0, 0, 1, st, 0, 0, 0));
      end
      if (md >= T) begin
        trap_seq(3);
        return;
      end
      push(1, r1(), 1, d, az, e(4, 0, 0, 0, 1, st, st, 0, 0));
      if (kind == 2) return;
    end
    if (kind != 3) push(1, r1(), r1(), d, az, e(5, 0, 0, 0, 0, 0, 1, 0, 1));
  endfunction
  initial begin
    logic [12:0] obs;
    int k, fd, md;
    reset_rec();
    instr(0, 0, 0, 1'b0, 1'b0);
    instr(1, 0, 2, 1'b0, 1'b0);
    instr(3, 1, 0, 1'b1, 1'b0);
    instr(3, 0, 0, 1'b0, 1'b0);
    instr(2, 2, 0, 1'b1, 1'b0);
    instr(4, 0, 0, 1'b0, 1'b0);
    instr(2, 0, 4, 1'b0, 1'b0);
    instr(2, 0, 3, 1'b0, 1'b0);
    instr(1, 0, 3, 1'b0, 1'b0);
    instr(0, 4, 0, 1'b0, 1'b0);
    instr(0, 3, 0, 1'b0, 1'b0);
    instr(1, 0, 5, 1'b0, 1'b1);
    instr(0, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      k = k < 2 ? 0 : k < 4 ? 1 : k < 6 ? 2 : k < 9 ? 3 : 4;
      fd = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, T - 1);
      md = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, T - 1);
      instr(k, fd, md, r1(), $urandom_range(0, 9) == 0 && md >= 2);
    end
    repeat (3) @(posedge clk);
    foreach (q[i]) begin
      @(negedge clk);
      {rst_n, imem_ack, dmem_ack, dec_mem_write, dec_reg_write, dec_mem_to_reg, dec_branch, dec_ill_instr, alu_zero} = q[i][21:13];
      #1;
      obs = {state, trap, trap_cause, imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_branch, rf_write};
      total++;
      assert (obs === q[i].exp) passed++;
      else $error("FAIL step%0d {state,trap,cause,ireq,irw,dreq,dwe,pcw,pcb,rfw}: got %b want %b", i, obs, q[i].exp);
    end
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    total++;
    assert ({state, trap, trap_cause, imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_branch, rf_write} === 13'b0) passed++;
    else $error("FAIL reset state: state=%0d trap=%b cause=%b", state, trap, trap_cause);
    rst_n = 1'b1;
    repeat (T + 2) @(negedge clk);
    #1;
    total++;
    assert (state === 3'd7 && trap === 1'b1 && trap_cause === 2'b10 && imem_req === 1'b0) passed++;
    else $error("FAIL expired fetch wait: state=%0d trap=%b cause=%b", state, trap, trap_cause);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
